// File: rtl/kbd_ctrl.sv
// -----------------------------------------------------------------------------
// kbd_ctrl -- CPU-side keyboard controller.
//
// Completes the keyboard driver's four-phase int_req/int_ack handshake. Each
// delivered ASCII byte goes into a small circular FIFO. The FIFO is exposed to
// the system bus as a data port and a status port. A level interrupt is raised
// while the FIFO holds data.
//
// Ports
//   clk       in   1   system clock (same clock as the keyboard driver)
//   rst_n     in   1   asynchronous active-low reset
//   int_req   in   1   driver request; kbd_data is valid while it is high
//   kbd_data  in   8   ASCII byte from the driver
//   int_ack   out  1   handshake acknowledge (registered)
//   rd_en     in   1   one-cycle bus read strobe
//   rd_sel    in   1   0 = data port (pops the FIFO), 1 = status port
//   rd_data   out  32  registered read result; holds when rd_en = 0
//   irq       out  1   registered "FIFO non-empty" interrupt
//
// Status word layout:
//   [31:12] 0, [11:4] count, [3] 0, [2] overflow (read-to-clear),
//   [1] full, [0] nonempty
// -----------------------------------------------------------------------------
module kbd_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_req,
    input  logic [7:0]  kbd_data,
    output logic        int_ack,
    input  logic        rd_en,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } hs_state_e;

    // Handshake FSM state and its registered output.
    hs_state_e state_q;
    logic      int_ack_q;

    // FIFO bookkeeping.
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic [7:0]            mem_q [DEPTH];

    // Bus side.
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;
    logic        irq_q;

    // Per-cycle events.
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;
    logic        empty;
    logic        full;
    logic        status_rd;
    logic [7:0]  count_ext;
    logic [31:0] status_word;

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    // A request is only taken in IDLE, so a long int_req pulse pushes once.
    assign push_req  = (state_q == IDLE) && int_req;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign status_rd = rd_en && rd_sel;
    assign pop       = rd_en && !rd_sel && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted then.
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && !push;

    assign count_ext   = 8'(count_q);
    assign status_word = {16'b0, 4'b0, count_ext, 1'b0, overflow_q, full, !empty};

    // NOTE: every signal assigned in always_comb takes a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // A dropped byte wins over the read-to-clear. The status word already
    // sampled the pre-read value, so an overflow in the same cycle is not lost.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (status_rd) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (rd_sel) begin
                rd_data_d = status_word;
            end else if (!empty) begin
                rd_data_d = {24'b0, mem_q[rd_ptr_q]};
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            int_ack_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (int_req) begin
                        state_q   <= ACK;
                        int_ack_q <= 1'b1;
                    end
                end
                // One unconditional cycle keeps int_ack high for at least
                // two cycles.
                ACK: begin
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!int_req) begin
                        state_q   <= IDLE;
                        int_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    int_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO control, read port and interrupt
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            // The pointers are exactly DEPTH_LOG2 bits wide, so they wrap
            // modulo DEPTH on their own.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            // This uses the registered count, so irq lags count by one cycle.
            irq_q      <= (count_q != '0);
        end
    end

    // NOTE: the storage array has no reset. Its contents are only visible
    // through count and the pointers, which are reset. Leaving it unreset lets
    // it map onto plain RAM or register-file cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= kbd_data;
        end
    end

    assign int_ack = int_ack_q;
    assign rd_data = rd_data_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kbd_ctrl -- self-checking bench for kbd_ctrl (DEPTH_LOG2 = 3).
//
// The reference model is a byte queue plus a sticky overflow flag. Each read
// pushes its expected 32-bit result into a scoreboard queue. A separate
// monitor pops that queue and compares whenever the DUT returns read data.
// Handshake timing, int_ack and irq are checked inline.
// -----------------------------------------------------------------------------
module tb_kbd_ctrl;

    localparam int DEPTH = 8;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        int_req  = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        rd_en    = 1'b0;
    logic        rd_sel   = 1'b0;
    logic        int_ack;
    logic [31:0] rd_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];   // scoreboard: expected read results
    logic [7:0]  model_q [$]; // reference FIFO contents
    logic        model_ovf = 1'b0;
    logic        rd_fire   = 1'b0;

    kbd_ctrl #(.DEPTH_LOG2(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .int_req  (int_req),
        .kbd_data (kbd_data),
        .int_ack  (int_ack),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_status();
        int n;
        n = model_q.size();
        return 32'(n * 16 + (model_ovf ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n > 0 ? 1 : 0));
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_ovf = 1'b1;
    endtask

    // Drive a read strobe for the coming edge and record its expected result.
    task automatic issue_read(input logic sel);
        rd_en  = 1'b1;
        rd_sel = sel;
        if (sel) begin
            exp_q.push_back(model_status());
            model_ovf = 1'b0;
        end else if (model_q.size() != 0) begin
            exp_q.push_back({24'b0, model_q.pop_front()});
        end else begin
            exp_q.push_back(32'h0);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_fire <= 1'b0;
        else        rd_fire <= rd_en;
    end

    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) check("sb_unexpected_read", 32'(exp_q.size()), 32'd1);
            else                   check("rd_data", rd_data, exp_q.pop_front());
        end
    end

    // ---------------- stimulus helpers (called on a negedge) ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic read(input logic sel);
        issue_read(sel);
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Hold int_req for 'hold' edges. int_ack must be high after each of the
    // first max(hold,2) edges and low after the next one.
    task automatic handshake(input logic [7:0] b, input int hold, input bit with_read);
        int hi;
        hi       = (hold < 2) ? 2 : hold;
        int_req  = 1'b1;
        kbd_data = b;
        if (with_read) issue_read(1'b0);
        model_push(b);
        for (int k = 1; k <= hi + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) rd_en = 1'b0;
            check("int_ack", 32'(int_ack), 32'(k <= hi));
            if (k == hold) int_req = 1'b0;
        end
        check("irq", 32'(irq), 32'(model_q.size() != 0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        int         op;

        // Reset
        idle(3);
        check("reset_int_ack", 32'(int_ack), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // 1: single handshake, held for 5 cycles
        handshake(8'h41, 5, 1'b0);
        read(1'b1);                 // 0x11
        read(1'b0);                 // 0x41
        read(1'b1);                 // 0x00
        idle(1);
        check("t1_irq_low", 32'(irq), 32'd0);

        // 2: fill to 8, overflow with a 9th byte, then drain past empty
        for (int i = 0; i < 9; i++) handshake(8'(8'h30 + i), 1 + int'($urandom_range(0, 2)), 1'b0);
        read(1'b1);                 // 0x87
        read(1'b1);                 // 0x83
        for (int i = 0; i < 9; i++) read(1'b0);
        read(1'b1);                 // 0x00

        // 3: pointer wrap, push 3 / pop 3, four times
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) handshake(8'(8'h60 + r * 3 + i), 1, 1'b0);
            for (int i = 0; i < 3; i++) read(1'b0);
        end
        read(1'b1);                 // 0x00

        // 4: push into a full FIFO in the same cycle as a data read
        for (int i = 0; i < 8; i++) handshake(8'($urandom), 2, 1'b0);
        handshake(8'hA5, 2, 1'b1);
        read(1'b1);                 // 0x83: still full, no overflow
        for (int i = 0; i < 8; i++) read(1'b0);   // last one is 0xA5

        // 5: reset while in WAIT_LOW with two bytes queued
        handshake(8'h11, 1, 1'b0);
        handshake(8'h22, 1, 1'b0);
        read(1'b1);                 // 0x21 leaves rd_data non-zero
        int_req  = 1'b1;
        kbd_data = 8'h5A;
        model_push(8'h5A);
        idle(3);                    // IDLE -> ACK -> WAIT_LOW
        check("t5_ack_before_reset", 32'(int_ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_reset_int_ack", 32'(int_ack), 32'd0);
        check("t5_reset_irq", 32'(irq), 32'd0);
        check("t5_reset_rd_data", rd_data, 32'h0);
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue_read(1'b1);           // returns the pre-push state: 0
        model_push(8'h5A);          // int_req still high, so it is a new request
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        check("t5_ack_after_release", 32'(int_ack), 32'd1);
        idle(2);
        int_req = 1'b0;
        idle(1);
        check("t5_ack_fall", 32'(int_ack), 32'd0);
        read(1'b1);                 // 0x11: pushed exactly once
        read(1'b0);                 // 0x5A
        read(1'b1);                 // 0x00

        // 6: int_req held for 100 cycles pushes once
        handshake(8'h7E, 100, 1'b0);
        read(1'b1);                 // 0x11
        read(1'b0);

        // Randomized mix of handshakes and reads
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 2));
            b  = 8'($urandom);
            case (op)
                0:       handshake(b, 1 + int'($urandom_range(0, 3)), 1'b0);
                1:       read(1'b0);
                default: read(1'b1);
            endcase
        end
        read(1'b1);

        idle(2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
